// File: rtl/salida_uart_pkg.sv
// Shared types and constants for the salida UART transmitter.
// Defining SALIDA_UART_HEX_EN switches a word from 4 raw bytes to 10 ASCII characters.
package salida_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

`ifdef SALIDA_UART_HEX_EN
    localparam int CHARS_PER_WORD = 10;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib - 4'd10};
    endfunction
`else
    localparam int CHARS_PER_WORD = 4;
`endif

endpackage

// File: rtl/salida_uart_tx_byte.sv
// One 8N1 frame: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
// A start request in the final stop-bit cycle chains the next frame with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | start bit (low) on the line
// DATA  | data bits, bit_cnt counts down remaining shifts
// STOP  | stop bit (high); done_o marks its last cycle
module uart_tx_byte
    import salida_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_o     <= 1'b1;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (!bit_end) begin
                baud_cnt <= baud_cnt - CW'(1);
            end
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state    <= START;
                        shreg    <= byte_i;
                        tx_o     <= 1'b0;
                        baud_cnt <= CW'(CLKS_PER_BIT - 1);
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx_o     <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_cnt  <= 3'd7;
                        baud_cnt <= CW'(CLKS_PER_BIT - 1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= CW'(CLKS_PER_BIT - 1);
                        if (bit_cnt == 3'd0) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baud_cnt == CW'(1)) begin
                        done_o <= 1'b1;
                    end
                    if (bit_end) begin
                        if (start_i) begin
                            state    <= START;
                            shreg    <= byte_i;
                            tx_o     <= 1'b0;
                            baud_cnt <= CW'(CLKS_PER_BIT - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/salida_uart_tx.sv
// salida_uart_tx: FIFO-buffers core write-back words and streams them on an 8N1 UART line.
// Build with SALIDA_UART_HEX_EN defined to send 8 hex digits + CR/LF per word instead of raw bytes.
//
// state | meaning
// IDLE  | line free; pops the FIFO head when one is present
// LOAD  | word latched, first character handed to the byte unit
// DATA  | remaining characters chained back-to-back, chars_left counts down
module salida_uart_tx
    import salida_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [31:0]                 dato_i,
    input  logic                        valid_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        overflow_o,
    output logic [$clog2(FIFO_DEPTH):0] nivel_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int PW           = $clog2(FIFO_DEPTH);
    localparam int NW           = PW + 1;

    // Assert immediately, release two edges later so no flop sees a runt reset edge.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] count;
    logic [NW-1:0] count_n;
    logic          full;
    logic          push_ok;
    logic          fifo_pop;
    logic [31:0]   word_q;
    logic [31:0]   word_next;
    logic [3:0]    chars_left;
    logic [7:0]    cur_char;
    logic          byte_start;
    logic          byte_done;
    logic          word_end;

    // Full is judged on the current count, so a push meeting a pop while full is still dropped.
    assign full     = (count == NW'(FIFO_DEPTH));
    assign push_ok  = valid_i & ~full;
    assign fifo_pop = (state == IDLE) & (count != '0);

    always_comb begin
        count_n = count;
        if (push_ok && !fifo_pop) begin
            count_n = count + NW'(1);
        end else if (!push_ok && fifo_pop) begin
            count_n = count - NW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= dato_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_n;
        end
    end

`ifdef SALIDA_UART_HEX_EN
    always_comb begin
        cur_char = hex_char(word_q[31:28]);
        if (state == DATA && chars_left == 4'd2) begin
            cur_char = ASCII_CR;
        end else if (state == DATA && chars_left == 4'd1) begin
            cur_char = ASCII_LF;
        end
    end

    assign word_next = {word_q[27:0], 4'd0};
`else
    assign cur_char  = word_q[7:0];
    assign word_next = {8'd0, word_q[31:8]};
`endif

    // Next character is requested in the last stop-bit cycle so frames abut on the line.
    assign byte_start = (state == LOAD) |
                        ((state == DATA) & byte_done & (chars_left != 4'd0));
    assign word_end   = (state == DATA) & byte_done & (chars_left == 4'd0);

    always_ff @(posedge clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= IDLE;
            word_q     <= '0;
            chars_left <= '0;
            busy_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            busy_o <= (count_n != '0) | fifo_pop | (state == LOAD) |
                      ((state == DATA) & ~word_end);
            if (valid_i && full) begin
                overflow_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        state  <= LOAD;
                        word_q <= mem[rd_ptr];
                    end
                end
                LOAD: begin
                    state      <= DATA;
                    word_q     <= word_next;
                    chars_left <= 4'(CHARS_PER_WORD - 1);
                end
                DATA: begin
                    if (byte_done) begin
                        if (chars_left != 4'd0) begin
                            word_q     <= word_next;
                            chars_left <= chars_left - 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign nivel_o = count;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i  (clk_i),
        .rst_ni (rst_int_n),
        .start_i(byte_start),
        .byte_i (cur_char),
        .tx_o   (tx_o),
        .done_o (byte_done)
    );

endmodule

// File: tb/tb_salida_uart_tx.sv
// Directed bench for salida_uart_tx: decodes the UART line and compares against expected characters.
module tb_salida_uart_tx;

    localparam int CPB = 16;
`ifdef SALIDA_UART_HEX_EN
    localparam int CHARS = 10;
`else
    localparam int CHARS = 4;
`endif
    localparam int BYTE_CYC = 10 * CPB;
    localparam int WORD_CYC = CHARS * BYTE_CYC;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] dato_i = '0;
    logic        valid_i = 1'b0;
    logic        tx_o;
    logic        busy_o;
    logic        overflow_o;
    logic [2:0]  nivel_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int frame_err = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rx_t [$];

    int          mon_st;
    logic [7:0]  mon_b;
    logic        mon_ab;
    int          pc;
    int          t0;
    int          low_cnt;
    logic [31:0] w;

    salida_uart_tx #(
        .CLK_HZ    (16),
        .BAUD      (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .dato_i    (dato_i),
        .valid_i   (valid_i),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .overflow_o(overflow_o),
        .nivel_o   (nivel_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got cycle %0d exp finish", cyc);
        $fatal(1, "bench did not finish");
    end

    // Line decoder: samples each bit at its centre on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && tx_o == 1'b0) begin
                mon_st = cyc;
                mon_ab = 1'b0;
                repeat (CPB / 2) begin
                    @(negedge clk_i);
                    if (!rst_ni) mon_ab = 1'b1;
                end
                if (!mon_ab && tx_o !== 1'b0) frame_err++;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) begin
                        @(negedge clk_i);
                        if (!rst_ni) mon_ab = 1'b1;
                    end
                    mon_b[k] = tx_o;
                end
                repeat (CPB) begin
                    @(negedge clk_i);
                    if (!rst_ni) mon_ab = 1'b1;
                end
                if (!mon_ab) begin
                    if (tx_o !== 1'b1) frame_err++;
                    rx_q.push_back(mon_b);
                    rx_t.push_back(mon_st);
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic add_word(input logic [31:0] wd);
`ifdef SALIDA_UART_HEX_EN
        logic [3:0] nib;
        for (int i = 7; i >= 0; i--) begin
            nib = wd[i*4 +: 4];
            exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib}));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(wd[i*8 +: 8]);
`endif
    endtask

    task automatic push(input logic [31:0] wd);
        dato_i  = wd;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (busy_o) check_val({tag, "_idle_timeout"}, 32'(busy_o), 32'd0);
    endtask

    task automatic check_stream(input string tag);
        check_val({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size())
                check_val($sformatf("%s_c%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
    endtask

    initial begin
        // reset values
        repeat (3) @(posedge clk_i);
        #1;
        check_val("rst_tx", 32'(tx_o), 32'd1);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_ovf", 32'(overflow_o), 32'd0);
        check_val("rst_nivel", 32'(nivel_o), 32'd0);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check_val("post_rst_tx", 32'(tx_o), 32'd1);

        // 1: single word, latency and byte order
        pc = cyc;
        push(32'h1234_A5C3);
        check_val("t1_nivel", 32'(nivel_o), 32'd1);
        check_val("t1_busy", 32'(busy_o), 32'd1);
`ifdef SALIDA_UART_HEX_EN
        add_word(32'h1234_A5C3);
`else
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
`endif
        wait_idle("t1", WORD_CYC + 100);
        check_val("t1_busy_len_ok", 32'((cyc - pc >= WORD_CYC) && (cyc - pc <= WORD_CYC + 5)), 32'd1);
        check_val("t1_nivel_end", 32'(nivel_o), 32'd0);
        check_val("t1_ovf", 32'(overflow_o), 32'd0);
        if (rx_t.size() > 0) check_val("t1_latency", 32'(rx_t[0] - pc), 32'd3);
        check_val("t1_frame_err", 32'(frame_err), 32'd0);
        check_stream("t1");

        // 2: six back-to-back pushes, sixth dropped
        pc = cyc;
        for (int k = 0; k < 6; k++) begin
            w = (32'h1111_1111 * (k + 1)) ^ 32'h00A5_5A00;
            push(w);
            if (k < 5) add_word(w);
        end
        check_val("t2_nivel_full", 32'(nivel_o), 32'd4);
        check_val("t2_ovf", 32'(overflow_o), 32'd1);

        // 3: push while full in the cycle the next word is popped
        t0 = pc + 3;
        wait_until(t0 + WORD_CYC);
        check_val("t3_nivel_before", 32'(nivel_o), 32'd4);
        push(32'hDEAD_0006);
        check_val("t3_nivel_after", 32'(nivel_o), 32'd3);
        check_val("t3_ovf", 32'(overflow_o), 32'd1);
        wait_idle("t2", 6 * WORD_CYC + 100);
        if (rx_t.size() > CHARS) begin
            check_val("t2_char_gap", 32'(rx_t[1] - rx_t[0]), 32'(BYTE_CYC));
            check_val("t2_word_gap", 32'(rx_t[CHARS] - rx_t[0]), 32'(WORD_CYC + 2));
            check_val("t2_first_start", 32'(rx_t[0]), 32'(t0));
        end
        check_val("t2_nivel_end", 32'(nivel_o), 32'd0);
        check_stream("t2");

        // 4: reset during data bit 4 of character 1
        pc = cyc;
        push(32'hAA00_00FF);
        push(32'h0BAD_0001);
        push(32'h0BAD_0002);
        t0 = pc + 3;
        wait_until(t0 + BYTE_CYC + 5 * CPB + CPB / 2);
        check_val("t4_tx_low_before", 32'(tx_o), 32'd0);
        check_val("t4_nivel_before", 32'(nivel_o), 32'd2);
        check_val("t4_ovf_before", 32'(overflow_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_val("t4_tx", 32'(tx_o), 32'd1);
        check_val("t4_nivel", 32'(nivel_o), 32'd0);
        check_val("t4_ovf", 32'(overflow_o), 32'd0);
        check_val("t4_busy", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        rx_q.delete();
        rx_t.delete();
        low_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i);
            #1;
            if (tx_o !== 1'b1) low_cnt++;
        end
        check_val("t4_line_idle", 32'(low_cnt), 32'd0);
        check_val("t4_no_frames", 32'(rx_q.size()), 32'd0);
        check_val("t4_busy_after", 32'(busy_o), 32'd0);
        rx_q.delete();
        rx_t.delete();

        // 5: pointer wrap, 12 words one word-time apart
        for (int i = 0; i < 12; i++) begin
            w = {8'(i) ^ 8'h3C, 8'hA0 + 8'(i), ~8'(i), 8'(i)};
            push(w);
            add_word(w);
            repeat (WORD_CYC - 1) @(posedge clk_i);
            #1;
        end
        wait_idle("t5", 2 * WORD_CYC);
        check_val("t5_ovf", 32'(overflow_o), 32'd0);
        check_val("t5_nivel_end", 32'(nivel_o), 32'd0);
        check_stream("t5");

`ifdef SALIDA_UART_HEX_EN
        // 6: ASCII encoding
        push(32'h00AB_09FF);
        exp_q = '{8'h30, 8'h30, 8'h41, 8'h42, 8'h30, 8'h39, 8'h46, 8'h46, 8'h0D, 8'h0A};
        wait_idle("t6", WORD_CYC + 100);
        check_stream("t6");
`endif

        check_val("frame_err_total", 32'(frame_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
